// File: rtl/branch_outcome_tracker_if.sv
// Signal bundle between fetch/EX and the branch outcome tracker.
// The master drives the push and resolve requests. The slave is the tracker.
interface branch_outcome_tracker_if #(
  parameter int LOWER = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                   push_valid;
  logic [LOWER-1:0]       push_addr;
  logic                   push_pred;
  logic                   push_ready;
  logic                   resolve_valid;
  logic                   resolve_taken;
  logic                   resolve_ready;
  logic                   bht_en;
  logic [LOWER-1:0]       bht_write_addr;
  logic                   bht_was_taken;
  logic                   mispredict;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]       resolved_cnt;
  logic [CNT_W-1:0]       mispred_cnt;

  modport master (
    output push_valid, push_addr, push_pred, resolve_valid, resolve_taken,
    input  push_ready, resolve_ready, bht_en, bht_write_addr, bht_was_taken,
           mispredict, occupancy, resolved_cnt, mispred_cnt
  );

  modport slave (
    input  push_valid, push_addr, push_pred, resolve_valid, resolve_taken,
    output push_ready, resolve_ready, bht_en, bht_write_addr, bht_was_taken,
           mispredict, occupancy, resolved_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_outcome_tracker.sv
// BHT update side: queues fetch-time predictions in program order, retires them on EX resolve,
// drives the BHT write port and flushes wrong-path entries on a misprediction.
module branch_outcome_tracker #(
  parameter int LOWER = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic                     clk,
  input logic                     arst_n,
  branch_outcome_tracker_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LOWER-1:0] entry_addr [DEPTH];
  logic             entry_pred [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next, wr_ptr_next;
  logic [PTR_W-1:0] occupancy;
  logic             full, empty, push_fire, pop_fire, miss;
  logic [LOWER-1:0] popped_addr;
  logic             popped_pred;

  logic             bht_en_reg, bht_was_taken_reg, mispredict_reg;
  logic [LOWER-1:0] bht_write_addr_reg;
  logic [CNT_W-1:0] resolved_cnt_reg, mispred_cnt_reg;

  // Pointers carry a wrap bit, so their difference is the entry count.
  assign occupancy = wr_ptr_reg - rd_ptr_reg;
  assign full      = (occupancy == PTR_W'(DEPTH));
  assign empty     = (occupancy == '0);
  assign push_fire = bus.push_valid && !full;
  assign pop_fire  = bus.resolve_valid && !empty;

  assign popped_addr = entry_addr[rd_ptr_reg[AW-1:0]];
  assign popped_pred = entry_pred[rd_ptr_reg[AW-1:0]];
  assign miss        = pop_fire && (popped_pred != bus.resolve_taken);

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (pop_fire)
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    // Mispredict: the same-cycle push and all younger entries are wrong-path.
    if (miss)
      wr_ptr_next = rd_ptr_reg + PTR_W'(1);
    else if (push_fire)
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_fire && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          entry_addr[gi] <= bus.push_addr;
          entry_pred[gi] <= bus.push_pred;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr_reg         <= '0;
      wr_ptr_reg         <= '0;
      bht_en_reg         <= 1'b0;
      bht_write_addr_reg <= '0;
      bht_was_taken_reg  <= 1'b0;
      mispredict_reg     <= 1'b0;
      resolved_cnt_reg   <= '0;
      mispred_cnt_reg    <= '0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      bht_en_reg     <= pop_fire;
      mispredict_reg <= miss;
      if (pop_fire) begin
        bht_write_addr_reg <= popped_addr;
        bht_was_taken_reg  <= bus.resolve_taken;
        if (resolved_cnt_reg != CNT_MAX)
          resolved_cnt_reg <= resolved_cnt_reg + CNT_W'(1);
        if (miss && (mispred_cnt_reg != CNT_MAX))
          mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.push_ready     = !full;
  assign bus.resolve_ready  = !empty;
  assign bus.occupancy      = occupancy;
  assign bus.bht_en         = bht_en_reg;
  assign bus.bht_write_addr = bht_write_addr_reg;
  assign bus.bht_was_taken  = bht_was_taken_reg;
  assign bus.mispredict     = mispredict_reg;
  assign bus.resolved_cnt   = resolved_cnt_reg;
  assign bus.mispred_cnt    = mispred_cnt_reg;
endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Self-checking bench for branch_outcome_tracker: directed vector table, corner sequences,
// randomized traffic against a queue-based reference model, and counter saturation at CNT_W=3.
module tb_branch_outcome_tracker;
  localparam int LOWER = 5;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int SAT_W = 3;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  branch_outcome_tracker_if #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  branch_outcome_tracker_if #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(SAT_W)) sbus ();

  branch_outcome_tracker #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus)
  );
  branch_outcome_tracker #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(SAT_W)) sat_dut (
    .clk(clk), .arst_n(arst_n), .bus(sbus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [LOWER-1:0] addr;
    logic             pred;
  } ent_t;

  // Reference model: an in-order queue plus the expected registered outputs.
  ent_t             mq[$];
  logic             m_en, m_taken, m_mis;
  logic [LOWER-1:0] m_addr;
  int               m_res, m_mc;
  int               cnt_max = (1 << CNT_W) - 1;

  typedef struct {
    logic             pv;
    logic [LOWER-1:0] pa;
    logic             pp;
    logic             rv;
    logic             rt;
    logic             e_en;
    logic [LOWER-1:0] e_addr;
    logic             e_taken;
    logic             e_mis;
    int               e_occ;
    int               e_res;
    int               e_mc;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(int pv, int pa, int pp, int rv, int rt,
                              int en, int ad, int tk, int ms, int occ, int res, int mc);
    vec_t v;
    v.pv = pv[0]; v.pa = pa[LOWER-1:0]; v.pp = pp[0]; v.rv = rv[0]; v.rt = rt[0];
    v.e_en = en[0]; v.e_addr = ad[LOWER-1:0]; v.e_taken = tk[0]; v.e_mis = ms[0];
    v.e_occ = occ; v.e_res = res; v.e_mc = mc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_en = 1'b0; m_taken = 1'b0; m_mis = 1'b0; m_addr = '0;
    m_res = 0; m_mc = 0;
  endtask

  // Applies the behavioural rules to the inputs present at a rising edge.
  task automatic model_edge();
    bit   push_ok, pop_ok, flush;
    ent_t e;
    push_ok = bus.push_valid && (mq.size() < DEPTH);
    pop_ok  = bus.resolve_valid && (mq.size() > 0);
    flush   = 1'b0;
    m_en    = 1'b0;
    m_mis   = 1'b0;
    if (pop_ok) begin
      e       = mq.pop_front();
      m_en    = 1'b1;
      m_addr  = e.addr;
      m_taken = bus.resolve_taken;
      m_mis   = (e.pred != bus.resolve_taken);
      if (m_res < cnt_max) m_res++;
      if (m_mis) begin
        if (m_mc < cnt_max) m_mc++;
        mq.delete();
        flush = 1'b1;
      end
    end
    if (push_ok && !flush)
      mq.push_back('{addr: bus.push_addr, pred: bus.push_pred});
  endtask

  task automatic check_all();
    check("bht_en", 32'(bus.bht_en), 32'(m_en));
    check("bht_write_addr", 32'(bus.bht_write_addr), 32'(m_addr));
    check("bht_was_taken", 32'(bus.bht_was_taken), 32'(m_taken));
    check("mispredict", 32'(bus.mispredict), 32'(m_mis));
    check("occupancy", 32'(bus.occupancy), 32'(mq.size()));
    check("push_ready", 32'(bus.push_ready), 32'(mq.size() < DEPTH));
    check("resolve_ready", 32'(bus.resolve_ready), 32'(mq.size() > 0));
    check("resolved_cnt", 32'(bus.resolved_cnt), 32'(m_res));
    check("mispred_cnt", 32'(bus.mispred_cnt), 32'(m_mc));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input int pv, input int pa, input int pp, input int rv, input int rt);
    bus.push_valid    = pv[0];
    bus.push_addr     = pa[LOWER-1:0];
    bus.push_pred     = pp[0];
    bus.resolve_valid = rv[0];
    bus.resolve_taken = rt[0];
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bht_en"}, 32'(bus.bht_en), 32'd0);
    check({tag, "_addr"}, 32'(bus.bht_write_addr), 32'd0);
    check({tag, "_taken"}, 32'(bus.bht_was_taken), 32'd0);
    check({tag, "_mispredict"}, 32'(bus.mispredict), 32'd0);
    check({tag, "_occupancy"}, 32'(bus.occupancy), 32'd0);
    check({tag, "_push_ready"}, 32'(bus.push_ready), 32'd1);
    check({tag, "_resolve_ready"}, 32'(bus.resolve_ready), 32'd0);
    check({tag, "_resolved_cnt"}, 32'(bus.resolved_cnt), 32'd0);
    check({tag, "_mispred_cnt"}, 32'(bus.mispred_cnt), 32'd0);
  endtask

  initial begin
    int saved_res;
    int exp_sat;
    drive(0, 0, 0, 0, 0);
    sbus.push_valid = 1'b0; sbus.push_addr = '0; sbus.push_pred = 1'b0;
    sbus.resolve_valid = 1'b0; sbus.resolve_taken = 1'b0;
    model_reset();
    #2;
    check_reset_values("por");
    @(posedge clk); #1;
    arst_n = 1'b1;

    // Tests 2 and 3: in-order correct predictions, then mispredict flush.
    tbl[0]  = mk(1,  3, 1, 0, 0,  0,  0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1,  7, 0, 0, 0,  0,  0, 0, 0, 2, 0, 0);
    tbl[2]  = mk(1, 12, 1, 0, 0,  0,  0, 0, 0, 3, 0, 0);
    tbl[3]  = mk(0,  0, 0, 1, 1,  1,  3, 1, 0, 2, 1, 0);
    tbl[4]  = mk(0,  0, 0, 1, 0,  1,  7, 0, 0, 1, 2, 0);
    tbl[5]  = mk(0,  0, 0, 1, 1,  1, 12, 1, 0, 0, 3, 0);
    tbl[6]  = mk(0,  0, 0, 0, 0,  0, 12, 1, 0, 0, 3, 0);
    tbl[7]  = mk(1,  5, 0, 0, 0,  0, 12, 1, 0, 1, 3, 0);
    tbl[8]  = mk(1,  6, 1, 0, 0,  0, 12, 1, 0, 2, 3, 0);
    tbl[9]  = mk(1,  9, 1, 0, 0,  0, 12, 1, 0, 3, 3, 0);
    tbl[10] = mk(0,  0, 0, 1, 1,  1,  5, 1, 1, 0, 4, 1);
    tbl[11] = mk(0,  0, 0, 0, 0,  0,  5, 1, 0, 0, 4, 1);
    for (int i = 0; i < 12; i++) begin
      drive(int'(tbl[i].pv), int'(tbl[i].pa), int'(tbl[i].pp), int'(tbl[i].rv), int'(tbl[i].rt));
      step();
      check($sformatf("vec%0d_en", i), 32'(bus.bht_en), 32'(tbl[i].e_en));
      check($sformatf("vec%0d_addr", i), 32'(bus.bht_write_addr), 32'(tbl[i].e_addr));
      check($sformatf("vec%0d_taken", i), 32'(bus.bht_was_taken), 32'(tbl[i].e_taken));
      check($sformatf("vec%0d_mis", i), 32'(bus.mispredict), 32'(tbl[i].e_mis));
      check($sformatf("vec%0d_occ", i), 32'(bus.occupancy), 32'(tbl[i].e_occ));
      check($sformatf("vec%0d_res", i), 32'(bus.resolved_cnt), 32'(tbl[i].e_res));
      check($sformatf("vec%0d_mc", i), 32'(bus.mispred_cnt), 32'(tbl[i].e_mc));
    end

    // Test 1: asynchronous reset with three entries in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1, 17 + i, i % 2, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    check("pre_reset_occ", 32'(bus.occupancy), 32'd3);
    #3;
    arst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("async_rst");
    @(posedge clk); #1;
    arst_n = 1'b1;

    // Test 4: fill, refused push while full, then pop+push traffic across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 20 + i, i % 2, 0, 0);
      step();
    end
    check("full_push_ready", 32'(bus.push_ready), 32'd0);
    drive(1, 31, 1, 0, 0);
    step();
    check("full_refused_occ", 32'(bus.occupancy), 32'd4);
    for (int k = 0; k < 6; k++) begin
      drive(1, 24 + k, k % 2, 1, int'(mq[0].pred));
      step();
    end
    while (mq.size() > 0) begin
      drive(0, 0, 0, 1, int'(mq[0].pred));
      step();
    end

    // Test 5: simultaneous push and correct pop at occupancy 2; resolve while empty.
    drive(1, 2, 1, 0, 0); step();
    drive(1, 4, 0, 0, 0); step();
    drive(1, 8, 1, 1, 1); step();
    check("simul_occ", 32'(bus.occupancy), 32'd2);
    drive(0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 1, 1); step();
    saved_res = int'(bus.resolved_cnt);
    drive(0, 0, 0, 1, 1); step();
    check("empty_resolve_en", 32'(bus.bht_en), 32'd0);
    check("empty_resolve_cnt", 32'(bus.resolved_cnt), 32'(saved_res));

    // Randomized traffic, mostly correctly predicted so the queue gets deep.
    for (int n = 0; n < 400; n++) begin
      int rt;
      if (mq.size() > 0 && ($urandom % 4) != 0) rt = int'(mq[0].pred);
      else rt = int'($urandom % 2);
      drive(int'($urandom % 2), int'($urandom % 32), int'($urandom % 2),
            int'($urandom % 2), rt);
      step();
    end
    drive(0, 0, 0, 0, 0);
    step();

    // Test 6: counter saturation on the CNT_W=3 instance.
    for (int i = 1; i <= 9; i++) begin
      sbus.push_valid = 1'b1; sbus.push_addr = 5'(i); sbus.push_pred = 1'b0;
      step();
      sbus.push_valid = 1'b0;
      sbus.resolve_valid = 1'b1; sbus.resolve_taken = 1'b1;
      step();
      sbus.resolve_valid = 1'b0;
      exp_sat = (i < 7) ? i : 7;
      check($sformatf("sat%0d_mispredict", i), 32'(sbus.mispredict), 32'd1);
      check($sformatf("sat%0d_addr", i), 32'(sbus.bht_write_addr), 32'(i));
      check($sformatf("sat%0d_mispred_cnt", i), 32'(sbus.mispred_cnt), 32'(exp_sat));
      check($sformatf("sat%0d_resolved_cnt", i), 32'(sbus.resolved_cnt), 32'(exp_sat));
    end
    step();
    step();
    check("sat_hold_mispred_cnt", 32'(sbus.mispred_cnt), 32'd7);
    check("sat_hold_resolved_cnt", 32'(sbus.resolved_cnt), 32'd7);
    check("sat_occ", 32'(sbus.occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
